input_window_buffer: RTL and testbench



---
 rtl/input_window_buffer_if.sv | 44 ++++
 rtl/input_window_buffer.sv | 119 +++++++++++
 tb/tb_input_window_buffer.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_window_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : input_window_buffer_if
// Description : Sample-ingest and window-read signal bundle for the
//               ping-pong input window buffer. The master side is the
//               producer/consumer pair; the slave side is the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface input_window_buffer_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 8
);
  // Ingest handshake
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;

  // Window status
  logic                  win_avail;
  logic                  rd_bank;
  logic [ADDR_WIDTH:0]   fill_level;
  logic [1:0]            win_count;

  // Window read port
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_err;
  logic                  win_release;

  modport master (
    output wr_valid, wr_data, rd_en, rd_addr, win_release,
    input  wr_ready, win_avail, rd_bank, fill_level, win_count,
           rd_data, rd_valid, rd_err
  );

  modport slave (
    input  wr_valid, wr_data, rd_en, rd_addr, win_release,
    output wr_ready, win_avail, rd_bank, fill_level, win_count,
           rd_data, rd_valid, rd_err
  );
endinterface
`default_nettype wire

// File: rtl/input_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : input_window_buffer
// Description : Ping-pong sample buffer. Samples fill one bank of DEPTH
//               words while the consumer randomly reads the other, completed
//               bank with a fixed 1-cycle latency and then releases it.
// Revision    : 1.0 - initial release
// ============================================================================
module input_window_buffer #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  wire                   clk,
  input  wire                   rst_n,
  input  wire                   flush,
  input_window_buffer_if.slave  bus
);

  // Index width that exactly spans one bank; rd_addr/wr_ptr are sliced to it.
  localparam int                  c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] c_last = ADDR_WIDTH'(DEPTH - 1);

  // Sample storage: two banks, never reset or flushed.
  logic [DATA_WIDTH-1:0] r_mem [2][DEPTH];

  logic                  r_wb;
  logic                  r_rb;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [1:0]            r_full;
  logic                  r_rd_valid;
  logic                  r_rd_err;
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  w_wr_ready;
  logic                  w_wr_accept;
  logic                  w_win_done;
  logic                  w_release;
  logic                  w_rd_legal;
  logic [1:0]            w_full_nxt;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // The bank being filled is never full, so a stall only happens when both
  // banks hold unreleased windows.
  assign w_wr_ready  = ~r_full[r_wb];
  assign w_wr_accept = bus.wr_valid & w_wr_ready & ~flush;
  assign w_win_done  = w_wr_accept & (r_wr_ptr == c_last);
  assign w_release   = bus.win_release & r_full[r_rb] & ~flush;
  assign w_rd_legal  = r_full[r_rb] & ({1'b0, bus.rd_addr} < c_depth);
  assign w_rd_word   = r_mem[r_rb][bus.rd_addr[c_idx_w-1:0]];

  // Completion and release always touch different banks, so both may apply.
  always_comb begin
    w_full_nxt = r_full;
    if (w_win_done) w_full_nxt[r_wb] = 1'b1;
    if (w_release)  w_full_nxt[r_rb] = 1'b0;
  end

  // Store accepted samples into the filling bank.
  always_ff @(posedge clk) begin
    if (w_wr_accept) r_mem[r_wb][r_wr_ptr[c_idx_w-1:0]] <= bus.wr_data;
  end

  // Window framing state: fill pointer, bank selects and full flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb     <= 1'b0;
      r_rb     <= 1'b0;
      r_wr_ptr <= '0;
      r_full   <= 2'b00;
    end else if (flush) begin
      r_wb     <= 1'b0;
      r_rb     <= 1'b0;
      r_wr_ptr <= '0;
      r_full   <= 2'b00;
    end else begin
      r_full <= w_full_nxt;
      if (w_win_done) begin
        r_wb     <= ~r_wb;
        r_wr_ptr <= '0;
      end else if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_release) r_rb <= ~r_rb;
    end
  end

  // Registered read port; rd_data holds its value unless a legal read lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_data  <= '0;
    end else if (flush) begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_rd_data  <= '0;
    end else if (bus.rd_en) begin
      r_rd_valid <= w_rd_legal;
      r_rd_err   <= ~w_rd_legal;
      if (w_rd_legal) r_rd_data <= w_rd_word;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end
  end

  assign bus.wr_ready   = w_wr_ready;
  assign bus.win_avail  = r_full[r_rb];
  assign bus.rd_bank    = r_rb;
  assign bus.win_count  = {1'b0, r_full[0]} + {1'b0, r_full[1]};
  assign bus.fill_level = {1'b0, r_wr_ptr};
  assign bus.rd_data    = r_rd_data;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_err     = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_input_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_window_buffer
// Description : Directed self-checking bench for input_window_buffer with
//               DEPTH=4 banks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_window_buffer;

  localparam int c_dw    = 16;
  localparam int c_aw    = 3;
  localparam int c_depth = 4;

  logic clk;
  logic rst_n;
  logic flush;

  int total;
  int bad;

  input_window_buffer_if #(.DATA_WIDTH(c_dw), .ADDR_WIDTH(c_aw)) bus ();

  input_window_buffer #(
    .DATA_WIDTH (c_dw),
    .ADDR_WIDTH (c_aw),
    .DEPTH      (c_depth)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream consecutive words with wr_valid held; leaves wr_valid low after.
  task automatic stream(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'(first + i);
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  // Issue one read and check the registered result one cycle later.
  task automatic read_chk(input string tag, input int addr, input int exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 3'(addr);
    tick();
    bus.rd_en   = 1'b0;
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    check({tag, "_data"},  32'(bus.rd_data),  32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    bus.wr_valid    = 1'b0;
    bus.wr_data     = '0;
    bus.rd_en       = 1'b0;
    bus.rd_addr     = '0;
    bus.win_release = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_wr_ready",  32'(bus.wr_ready),   32'd1);
    check("rst_win_avail", 32'(bus.win_avail),  32'd0);
    check("rst_win_count", 32'(bus.win_count),  32'd0);
    check("rst_fill",      32'(bus.fill_level), 32'd0);
    check("rst_rd_valid",  32'(bus.rd_valid),   32'd0);
    check("rst_rd_err",    32'(bus.rd_err),     32'd0);
    check("rst_rd_data",   32'(bus.rd_data),    32'd0);
    rst_n = 1'b1;
    tick();

    // First window 1..4 into bank 0
    bus.wr_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.wr_data = 16'(i);
      tick();
      check("fill_step", 32'(bus.fill_level), 32'(i % 4));
    end
    bus.wr_valid = 1'b0;
    check("w0_avail", 32'(bus.win_avail), 32'd1);
    check("w0_bank",  32'(bus.rd_bank),   32'd0);
    check("w0_count", 32'(bus.win_count), 32'd1);

    // Back-to-back reads of bank 0: addr 3,0,2 -> 4,1,3
    bus.rd_en   = 1'b1;
    bus.rd_addr = 3'd3;
    check("rd_lat0", 32'(bus.rd_valid), 32'd0);
    tick();
    check("rd_a3_valid", 32'(bus.rd_valid), 32'd1);
    check("rd_a3_data",  32'(bus.rd_data),  32'd4);
    bus.rd_addr = 3'd0;
    tick();
    check("rd_a0_valid", 32'(bus.rd_valid), 32'd1);
    check("rd_a0_data",  32'(bus.rd_data),  32'd1);
    bus.rd_addr = 3'd2;
    tick();
    check("rd_a2_valid", 32'(bus.rd_valid), 32'd1);
    check("rd_a2_data",  32'(bus.rd_data),  32'd3);
    bus.rd_en = 1'b0;
    tick();
    check("rd_idle_valid", 32'(bus.rd_valid), 32'd0);
    check("rd_idle_hold",  32'(bus.rd_data),  32'd3);

    // Second window 5..8 into bank 1; both banks full
    stream(5, 4);
    check("both_count", 32'(bus.win_count), 32'd2);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'd9;
    check("both_ready", 32'(bus.wr_ready), 32'd0);
    tick();
    check("stall_fill",  32'(bus.fill_level), 32'd0);
    check("stall_count", 32'(bus.win_count),  32'd2);
    bus.win_release = 1'b1;
    tick();
    bus.win_release = 1'b0;
    check("rel_bank",  32'(bus.rd_bank),    32'd1);
    check("rel_count", 32'(bus.win_count),  32'd1);
    check("rel_ready", 32'(bus.wr_ready),   32'd1);
    check("rel_fill",  32'(bus.fill_level), 32'd0);
    tick();
    bus.wr_valid = 1'b0;
    check("w9_fill", 32'(bus.fill_level), 32'd1);
    read_chk("rd_b1a0", 0, 5);

    // Out-of-range read: error pulse, data held
    bus.rd_en   = 1'b1;
    bus.rd_addr = 3'd4;
    tick();
    bus.rd_en = 1'b0;
    check("oor_err",   32'(bus.rd_err),   32'd1);
    check("oor_valid", 32'(bus.rd_valid), 32'd0);
    check("oor_hold",  32'(bus.rd_data),  32'd5);
    tick();
    check("oor_pulse", 32'(bus.rd_err), 32'd0);

    // Release bank 1; bank 0 partial so no window is available
    bus.win_release = 1'b1;
    tick();
    bus.win_release = 1'b0;
    check("rel1_bank",  32'(bus.rd_bank),   32'd0);
    check("rel1_avail", 32'(bus.win_avail), 32'd0);
    check("rel1_count", 32'(bus.win_count), 32'd0);

    // Read with no window available
    bus.rd_en   = 1'b1;
    bus.rd_addr = 3'd0;
    tick();
    bus.rd_en = 1'b0;
    check("nowin_err",   32'(bus.rd_err),   32'd1);
    check("nowin_valid", 32'(bus.rd_valid), 32'd0);
    check("nowin_hold",  32'(bus.rd_data),  32'd5);
    tick();
    check("nowin_pulse", 32'(bus.rd_err), 32'd0);

    // Release with nothing available is ignored
    bus.win_release = 1'b1;
    tick();
    bus.win_release = 1'b0;
    check("norel_bank", 32'(bus.rd_bank),    32'd0);
    check("norel_fill", 32'(bus.fill_level), 32'd1);
    check("norel_err",  32'(bus.rd_err),     32'd0);

    // Complete bank 0 (9..12), then fill bank 1 with 13..15
    stream(10, 3);
    check("b0_done_avail", 32'(bus.win_avail), 32'd1);
    stream(13, 3);
    check("b1_part_fill", 32'(bus.fill_level), 32'd3);

    // Last word of bank 1 in the same cycle as releasing bank 0
    bus.wr_valid    = 1'b1;
    bus.wr_data     = 16'd16;
    bus.win_release = 1'b1;
    tick();
    bus.wr_valid    = 1'b0;
    bus.win_release = 1'b0;
    check("same_bank",  32'(bus.rd_bank),    32'd1);
    check("same_count", 32'(bus.win_count),  32'd1);
    check("same_ready", 32'(bus.wr_ready),   32'd1);
    check("same_fill",  32'(bus.fill_level), 32'd0);
    read_chk("rd_b1a3", 3, 16);
    read_chk("rd_b1a0b", 0, 13);
    stream(17, 1);
    check("wb0_fill",  32'(bus.fill_level), 32'd1);
    check("wb0_count", 32'(bus.win_count),  32'd1);

    // Flush mid-fill, with a competing write that must be dropped
    stream(18, 1);
    check("pre_flush_fill", 32'(bus.fill_level), 32'd2);
    flush        = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'h0099;
    tick();
    flush        = 1'b0;
    bus.wr_valid = 1'b0;
    check("fl_count", 32'(bus.win_count),  32'd0);
    check("fl_fill",  32'(bus.fill_level), 32'd0);
    check("fl_avail", 32'(bus.win_avail),  32'd0);
    check("fl_bank",  32'(bus.rd_bank),    32'd0);
    check("fl_data",  32'(bus.rd_data),    32'd0);
    stream(21, 4);
    check("fl_new_avail", 32'(bus.win_avail), 32'd1);
    check("fl_new_bank",  32'(bus.rd_bank),   32'd0);
    read_chk("rd_fl_a1", 1, 22);

    // Asynchronous reset mid-fill
    stream(31, 2);
    check("pre_rst_fill", 32'(bus.fill_level), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_count", 32'(bus.win_count),  32'd0);
    check("ar_fill",  32'(bus.fill_level), 32'd0);
    check("ar_avail", 32'(bus.win_avail),  32'd0);
    check("ar_data",  32'(bus.rd_data),    32'd0);
    check("ar_ready", 32'(bus.wr_ready),   32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    stream(41, 4);
    check("ar_new_avail", 32'(bus.win_avail), 32'd1);
    check("ar_new_bank",  32'(bus.rd_bank),   32'd0);
    check("ar_new_count", 32'(bus.win_count), 32'd1);
    read_chk("rd_ar_a3", 3, 44);
    read_chk("rd_ar_a0", 0, 41);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
